// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and early-out divide special cases.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [XLEN-1:0]   opb, opb_nxt;
  logic [2:0]        op_q, op_nxt;
  logic              neg_q, neg_nxt;
  logic [XLEN-1:0]   result_nxt;
  logic              busy_nxt, done_nxt;

  // Operand decode at accept: signedness, magnitudes and divide early-outs
  logic              a_signed_c, b_signed_c, sa_c, sb_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic              is_div_c, div0_c, ovf_c, special_c;
  logic [XLEN-1:0]   special_res_c;

  assign a_signed_c = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed_c = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa_c       = a_signed_c & rs1[XLEN-1];
  assign sb_c       = b_signed_c & rs2[XLEN-1];
  assign a_mag_c    = sa_c ? -rs1 : rs1;
  assign b_mag_c    = sb_c ? -rs2 : rs2;

  assign is_div_c   = op[2];
  assign div0_c     = (rs2 == {XLEN{1'b0}});
  assign ovf_c      = !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
  assign special_c  = is_div_c && (div0_c || ovf_c);
  // REM/REMU: rs1 on divide-by-zero, 0 on overflow; DIV/DIVU: all ones, or rs1 (MIN) on overflow
  assign special_res_c = op[1] ? (div0_c ? rs1 : {XLEN{1'b0}})
                               : (div0_c ? {XLEN{1'b1}} : rs1);

  // One iteration of the unsigned core; acc holds {hi, lo} for both operations
  logic [XLEN:0]     mul_sum_c;
  logic [ACC_W-1:0]  mul_step_c;
  logic [XLEN:0]     div_upper_c, div_diff_c;
  logic              div_ge_c;
  logic [ACC_W-1:0]  div_step_c;
  logic [ACC_W-1:0]  step_c;

  assign mul_sum_c   = {1'b0, acc[ACC_W-1:XLEN]} + {1'b0, (acc[0] ? opb : {XLEN{1'b0}})};
  assign mul_step_c  = {mul_sum_c, acc[XLEN-1:1]};

  assign div_upper_c = acc[ACC_W-1:XLEN-1];
  assign div_diff_c  = div_upper_c - {1'b0, opb};
  assign div_ge_c    = ~div_diff_c[XLEN];
  assign div_step_c  = div_ge_c ? {div_diff_c[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                                : {div_upper_c[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  assign step_c      = op_q[2] ? div_step_c : mul_step_c;

  // Sign fix-up applied to the value produced by the final step
  logic [ACC_W-1:0]  prod_fix_c;
  logic [XLEN-1:0]   div_word_c, div_fix_c, final_c;

  assign prod_fix_c = neg_q ? -step_c : step_c;
  assign div_word_c = op_q[1] ? step_c[ACC_W-1:XLEN] : step_c[XLEN-1:0];
  assign div_fix_c  = neg_q ? -div_word_c : div_word_c;
  assign final_c    = op_q[2] ? div_fix_c
                    : ((op_q[1:0] == 2'b00) ? prod_fix_c[XLEN-1:0] : prod_fix_c[ACC_W-1:XLEN]);

  // Next-state and datapath load logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opb_nxt    = opb;
    op_nxt     = op_q;
    neg_nxt    = neg_q;
    result_nxt = result;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (!flush && start) begin
          op_nxt  = op;
          neg_nxt = (op == OP_REM) ? sa_c : (sa_c ^ sb_c);
          cnt_nxt = {CNT_W{1'b0}};
          if (special_c) begin
            state_nxt  = DONE;
            result_nxt = special_res_c;
          end else begin
            state_nxt = CALC;
            acc_nxt   = {{XLEN{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
            opb_nxt   = is_div_c ? b_mag_c : a_mag_c;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt = step_c;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nxt  = DONE;
            result_nxt = final_c;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == CALC);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= {CNT_W{1'b0}};
      acc    <= {ACC_W{1'b0}};
      opb    <= {XLEN{1'b0}};
      op_q   <= 3'b000;
      neg_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {XLEN{1'b0}};
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opb    <= opb_nxt;
      op_q   <= op_nxt;
      neg_q  <= neg_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus a
// cycle-level handshake model compared against the DUT on every negedge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: begin sp = longint'(sa) * longint'(sb); return sp[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); return sp[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Handshake model: cycles remaining until done, expected flags and held result
  int          m_rem = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_result = 32'h0;
    end else begin
      m_done = 1'b0;
      if (flush) begin
        m_rem = 0; m_busy = 1'b0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
        end
      end else if (start) begin
        m_pend = ref_op(op, rs1, rs2);
        if (is_special(op, rs1, rs2)) begin
          m_done = 1'b1; m_result = m_pend;
        end else begin
          m_rem = 32; m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("result", result, m_result);
    if (busy && done) check("busy_and_done", 32'(1), 32'(0));
  end

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 3'($urandom);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    check({name, "_model"}, ref_op(o, a, b), exp);
    @(posedge clk); #1;
    issue(o, a, b);
    wait_done(1, lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int dones;

    #1 rst = 1'b1;
    #2;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_result", result, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    run_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",    3'd3, 32'd7,        32'hFFFFFFFD, 32'h00000006, 33);
    run_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu_by0", 3'd5, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",  3'd6, 32'h1234,     32'h0,        32'h1234,     1);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

    // start during CALC is ignored; start in the DONE cycle is accepted
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    issue(3'd5, 32'd100, 32'd7);
    wait_done(6, lat);
    check("ignore_latency", 32'(lat), 32'(33));
    check("ignore_result", result, 32'd15);
    issue(3'd5, 32'd100, 32'd7);
    wait_done(1, lat);
    check("b2b_latency", 32'(lat), 32'(33));
    check("b2b_result", result, 32'd14);

    // flush at step 10
    @(posedge clk); #1;
    issue(3'd0, 32'h1111, 32'h2222);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'(0));
    check("flush_busy", 32'(busy), 32'(0));
    check("flush_result_held", result, 32'd14);

    // asynchronous reset at step 20
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", result, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    // randomized traffic: starts while busy, occasional flushes, edge operands
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 2);
      op    = 3'($urandom);
      rs1   = pick();
      rs2   = pick();
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
